// File: rtl/hit_judge.sv
// hit_judge: per-lane note judge feeding the scoreboard.
// Watches the player key and the lane's hit-zone status and decides, once per
// note, whether it was hit (short or long) or missed.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   resetn     asynchronous active-low reset
//   key        raw player button, active-high, asynchronous to clk
//   zone_valid high while a note occupies the hit zone (synchronous)
//   zone_long  note in the zone is a long note (meaningful with zone_valid)
//   increment  one-cycle hit pulse to the scoreboard
//   islong     qualifies increment: 1 = long-note hit, 0 whenever increment=0
//   miss       one-cycle miss pulse
//   combo      consecutive-hit count, saturating, cleared by a miss
module hit_judge #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned COMBO_W     = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               key,
  input  logic               zone_valid,
  input  logic               zone_long,
  output logic               increment,
  output logic               islong,
  output logic               miss,
  output logic [COMBO_W-1:0] combo
);

  // HOLD_CYCLES is at most 255, so an 8-bit hold counter always suffices.
  localparam int unsigned        CNT_W     = 8;
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [COMBO_W-1:0] COMBO_MAX = {COMBO_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic             long_q;
  logic [CNT_W-1:0] hold_cnt;

  logic key_m;
  logic key_s;
  logic key_d;
  logic press;

  // Judgement for the current cycle, shared by the FSM and the combo counter.
  logic hit;
  logic hit_long;
  logic fault;

  // Key synchronizer and edge history. All three flops preset high so a key
  // already held while reset releases never looks like a fresh press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
      key_d <= 1'b1;
    end else begin
      key_m <= key;
      key_s <= key_m;
      key_d <= key_s;
    end
  end

  assign press = key_s & ~key_d;

  // Hit / miss decision for this cycle. In ARMED a press beats a falling
  // zone_valid; in HOLD zone_valid is deliberately not looked at.
  always_comb begin
    hit      = 1'b0;
    hit_long = 1'b0;
    fault    = 1'b0;
    case (state)
      ARMED: begin
        if (press && !long_q) begin
          hit = 1'b1;
        end else if (!press && !zone_valid) begin
          fault = 1'b1;
        end
      end
      HOLD: begin
        if (!key_s) begin
          fault = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          hit      = 1'b1;
          hit_long = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Note FSM with registered pulse outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      long_q    <= 1'b0;
      hold_cnt  <= '0;
      increment <= 1'b0;
      islong    <= 1'b0;
      miss      <= 1'b0;
    end else begin
      increment <= hit;
      islong    <= hit_long;
      miss      <= fault;
      case (state)
        IDLE: begin
          // Presses here are ignored; only a note arriving arms the lane.
          if (zone_valid) begin
            state  <= ARMED;
            long_q <= zone_long;
          end
        end
        ARMED: begin
          if (press) begin
            if (long_q) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end else begin
              state <= DONE;
            end
          end else if (!zone_valid) begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (hit || fault) begin
            state <= DONE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          // A continuous zone_valid is one note: wait for it to drop.
          if (!zone_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Combo counter: saturating count of hits since the last miss.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      combo <= '0;
    end else if (fault) begin
      combo <= '0;
    end else if (hit && (combo != COMBO_MAX)) begin
      combo <= combo + 1'b1;
    end
  end

endmodule
